// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared RV32M encodings, FSM states and special-case results
package muldiv_sequencer_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 5;
  localparam logic [6:0] OPCODE_OP = 7'b0110011;
  localparam logic [6:0] FUNC7_M = 7'b0000001;
  localparam logic [2:0] F3_MUL = 3'b000;
  localparam logic [2:0] F3_MULH = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU = 3'b011;
  localparam logic [2:0] F3_DIV = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;
  localparam logic [MD_WIDTH-1:0] DIV0_QUOT = '1;
  localparam logic [MD_WIDTH-1:0] OVF_QUOT = 32'h8000_0000;
  localparam logic [MD_WIDTH-1:0] OVF_REM = '0;
  localparam logic [MD_WIDTH-1:0] INT_MIN = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: one shift-add / restoring-divide step per cycle plus final sign fix
module muldiv_iter_core
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_is_div,
  input  logic             i_neg,
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_mag_a,
  input  logic [WIDTH-1:0] i_mag_b,
  output logic [WIDTH-1:0] o_result
);
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_lo;
  // next accumulator: multiply keeps {high partial, multiplier}, divide keeps {remainder, dividend/quotient}
  always_comb begin
    w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opb};
    w_next = !i_is_div ? {w_add, r_acc[WIDTH-1:1]} :
             w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0} :
             {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  end
  // sign correction and half / quotient / remainder selection
  always_comb begin
    w_prod = i_neg ? -r_acc : r_acc;
    w_hi = i_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_lo = i_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    o_result = i_is_div ? (i_sel[1] ? w_hi : w_lo) :
               (i_sel == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
  end
  // accumulator and divisor/multiplicand registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_opb <= '0;
    end else if (i_load) begin
      r_acc <= {{WIDTH{1'b0}}, i_mag_a};
      r_opb <= i_mag_b;
    end else if (i_step) begin
      r_acc <= w_next;
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: RV32M multi-cycle controller with fast path for divide corner cases
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_func3,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_func3;
  logic             r_neg;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_neg;
  logic             w_b_zero;
  logic             w_ovf;
  logic             w_special;
  logic [WIDTH-1:0] w_special_res;
  logic             w_accept;
  logic [WIDTH-1:0] w_core_result;
  // operand signedness, magnitudes and special-case detection
  always_comb begin
    w_a_neg = i_operand_a[WIDTH-1] & ~(i_func3[0] & (i_func3[1] | i_func3[2]));
    w_b_neg = i_operand_b[WIDTH-1] & (i_func3[2] ? ~i_func3[0] : ~i_func3[1]);
    w_mag_a = w_a_neg ? -i_operand_a : i_operand_a;
    w_mag_b = w_b_neg ? -i_operand_b : i_operand_b;
    w_neg = (i_func3[2] & i_func3[1]) ? w_a_neg : w_a_neg ^ w_b_neg;
    w_b_zero = i_operand_b == '0;
    w_ovf = i_func3[2] & ~i_func3[0] & (i_operand_a == INT_MIN) & (i_operand_b == '1);
    w_special = i_func3[2] & (w_b_zero | w_ovf);
    w_special_res = i_func3[1] ? (w_b_zero ? i_operand_a : OVF_REM) : (w_b_zero ? DIV0_QUOT : OVF_QUOT);
    w_accept = (r_state == IDLE) & i_start & ~i_flush;
  end
  assign o_stall = (r_state != IDLE) | (i_start & ~w_special);
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_result = r_result;
  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .i_clk    (i_clk),
    .i_rst    (i_reset),
    .i_load   (w_accept & ~w_special),
    .i_step   ((r_state == CALC) & ~i_flush),
    .i_is_div (r_func3[2]),
    .i_neg    (r_neg),
    .i_sel    (r_func3[1:0]),
    .i_mag_a  (w_mag_a),
    .i_mag_b  (w_mag_b),
    .o_result (w_core_result)
  );
  // control FSM: accept or fast-path in IDLE, iterate in CALC, publish in FIX
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_func3 <= '0;
      r_neg <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state != IDLE && i_flush) begin
        r_state <= IDLE;
        r_busy <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (w_accept) begin
            if (w_special) begin
              r_result <= w_special_res;
              r_done <= 1'b1;
            end else begin
              r_state <= CALC;
              r_busy <= 1'b1;
              r_cnt <= '0;
              r_func3 <= i_func3;
              r_neg <= w_neg;
            end
          end
          CALC: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH-1)) r_state <= FIX;
          end
          FIX: begin
            r_result <= w_core_result;
            r_done <= 1'b1;
            r_state <= IDLE;
            r_busy <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed checks against an arithmetic reference model
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  f3;
  logic [31:0] a, b;
  logic        busy, stall, done;
  logic [31:0] result;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_res;

  muldiv_sequencer dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_func3(f3),
    .i_operand_a(a), .i_operand_b(b), .i_flush(flush),
    .o_busy(busy), .o_stall(stall), .o_done(done), .o_result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, uy;
    logic [63:0] p;
    logic ovf;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'b0, y});
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic logic is_fast(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    return op[2] && (y == 0 || ((op == 3'd4 || op == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // issues one op; bs_at > 0 raises a stray START that many edges after acceptance
  task automatic run_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb, input int bs_at);
    logic [31:0] exp;
    logic sp, stall_ok;
    int cyc;
    exp = ref_model(op, va, vb);
    sp = is_fast(op, va, vb);
    f3 = op; a = va; b = vb; start = 1'b1;
    #1;
    check("stall_req", stall, !sp);
    tick;
    start = 1'b0;
    if (sp) begin
      check("fast_done", done, 1);
      check("fast_result", result, exp);
      check("fast_busy", busy, 0);
      check("fast_stall", stall, 0);
    end else begin
      cyc = 0;
      stall_ok = 1'b1;
      while (!done && cyc < 40) begin
        if (!stall || !busy) stall_ok = 1'b0;
        start = (bs_at > 0) && (cyc + 1 == bs_at);
        if (start) begin f3 = op ^ 3'b101; a = ~va; b = vb + 1; end
        tick;
        start = 1'b0;
        cyc++;
      end
      check("latency", cyc, 33);
      check("stall_while_busy", stall_ok, 1);
      check("result", result, exp);
      check("stall_at_done", stall, 0);
    end
    tick;
    check("done_pulse", done, 0);
    check("result_hold", result, exp);
    last_res = exp;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = '0; a = '0; b = '0;
    tick; tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    rst = 1'b0;
    tick;
    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 0);
    run_op(3'd4, 32'd5, 32'd0, 0);
    run_op(3'd7, 32'd5, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5);
    // FLUSH together with START in IDLE: nothing accepted
    f3 = 3'd4; a = 32'd9; b = 32'd0; start = 1'b1; flush = 1'b1;
    tick;
    start = 1'b0; flush = 1'b0;
    check("flush_start_done", done, 0);
    check("flush_start_busy", busy, 0);
    check("flush_start_result", result, last_res);
    // FLUSH at E+10 with a stray START at E+5, then a new op at E+12
    f3 = 3'd4; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    f3 = 3'd3; a = 32'hFFFF_FFFF; b = 32'h2; start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_start_ignored", busy, 1);
    repeat (4) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    check("flush_result", result, last_res);
    tick;
    check("flush_no_done", done, 0);
    run_op(3'd5, 32'd100, 32'd7, 0);
    // RESET at E+5 mid-CALC
    f3 = 3'd0; a = 32'd7; b = 32'd3; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    seen = 1'b0;
    repeat (40) begin tick; if (done) seen = 1'b1; end
    check("midrst_no_done", seen, 0);
    last_res = '0;
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic [31:0] x, y;
      int r;
      op = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) y = '0;
      if (r == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      if (r == 2) y = $urandom_range(1, 15);
      if (r == 3) x = $urandom_range(0, 50);
      run_op(op, x, y, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and datapath for the RV32M multiply/divide instructions, sitting beside the ALU in the EX stage.
- Accepts one operation from the decode/EX control, runs a 32-iteration shift-add or restoring-divide sequence, and drives STALL to freeze the pipeline until RESULT is ready.
- Divide-by-zero and signed-overflow cases are resolved in a fast path.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported and verified.
- CNT_W, 5, iteration counter width, equal to clog2(WIDTH).

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  synchronous, active-high reset
- START  input  1  request; valid only when an M-extension op (OPCODE 0110011, FUNC7 0000001) is in EX
- FUNC3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- OPERAND_A  input  WIDTH  rs1 value
- OPERAND_B  input  WIDTH  rs2 value
- FLUSH  input  1  abort the in-flight operation (branch/jump redirect)
- BUSY  output  1  registered; high while state != IDLE
- STALL  output  1  combinational; pipeline hold request
- DONE  output  1  registered; one-cycle result-valid pulse
- RESULT  output  WIDTH  registered result; holds until the next completion

Behaviour:
- Clock and reset: one clock CLK; reset RESET is synchronous and active-high.
- Reset values: on an edge with RESET=1, state=IDLE, counter=0, BUSY=0, DONE=0, RESULT=0, and all internal registers are cleared. RESET has priority over FLUSH and START, including mid-operation.
- States: IDLE, CALC, FIX.
- IDLE:
  - START=1 with a normal op at edge E: latch FUNC3, the operand magnitudes and the result sign, clear the accumulator and counter, and go to CALC.
  - START=1 with a special case: set RESULT and DONE=1 at edge E and stay in IDLE.
- CALC:
  - One iteration per edge; counter increments each edge.
  - Multiply: unsigned shift-add on magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring step, shifting the remainder left and subtracting the divisor when the remainder is >= the divisor.
  - After the edge where counter=WIDTH-1 (edge E+32), go to FIX.
- FIX: apply sign correction, select the low or high product half or the quotient/remainder, register RESULT, set DONE=1 (edge E+33), and go to IDLE.
- DONE: high for exactly one cycle after its setting edge, then cleared.
- STALL = (state != IDLE) OR (START AND NOT special). STALL is low in the cycle DONE is high, so EX consumes RESULT and advances.
- Signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Product is negated when the operand signs differ.
  - Quotient sign = sign(A) XOR sign(B). Remainder sign = sign(A).
- Special cases, all fast path, DONE at edge E, no stall:
  - Divide-by-zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
  - Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- START while state != IDLE: ignored. No queuing.
- FLUSH=1 at any edge with state != IDLE: go to IDLE, no DONE, RESULT unchanged.
- FLUSH=1 with START=1 in IDLE: the request is not accepted and no fast-path DONE is produced.
- Counter wrap: the counter is never reused without being cleared on acceptance.

Decomposition:
- Shared package (the M-extension definitions):
  - FUNC3 encodings for the eight M ops.
  - M-extension FUNC7 constant 0000001.
  - State enum: IDLE, CALC, FIX.
  - Special-case result constants.
- One natural sub-module: muldiv_iter_core, the per-iteration shift-add/restoring-subtract datapath plus sign fix. The FSM, counter and handshake stay in muldiv_sequencer.

Test Plan:
- MUL A=0x00000007, B=0xFFFFFFFD, START at E -> STALL high E..E+32, DONE only after E+33, RESULT=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. Each completes at E+33.
- DIV 0xFFFFFFF9 / 0x00000002 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002.
- DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 0x00000005, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same -> 0. Each gives DONE at edge E and STALL low.
- FLUSH at E+10 -> BUSY=0 after E+10, no DONE, RESULT unchanged. START at E+5 while busy is ignored. New START at E+12 completes at E+45 with the correct value.
- RESET at E+5 mid-CALC -> BUSY=0, DONE=0, RESULT=0 after that edge. No DONE follows.
